id_operand_unit: RTL and testbench
==================================

ID_OPERAND_UNIT -- requirements
Module: id_operand_unit

Interface
REQ-001 Parameter NUM_FWD, default 3: number of bypass sources, index 0 = youngest (EX), rising index = older.
REQ-002 Parameter DATA_W, default 32: register/operand width.
REQ-003 Parameter LAT_W, default 6: width of long-latency countdown.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
REQ-006 stall  in  6  pipeline stall vector; bit1 = IF held, bit2 = ID held.
REQ-007 flush  in  1  discard ID contents.
REQ-008 if_valid, if_pc  in  1, 32  fetch-stage valid and PC.
REQ-009 inst_sram_rdata  in  32  instruction SRAM read data.
REQ-010 need_rs, need_rt  in  1, 1  decoder flags: instruction reads rs / rt.
REQ-011 rf_rdata1, rf_rdata2  in  DATA_W each  regfile read data for rs, rt.
REQ-012 fwd_we, fwd_is_load  in  NUM_FWD each  per-source write enable; result not yet available.
REQ-013 fwd_waddr, fwd_wdata  in  NUM_FWD*5, NUM_FWD*DATA_W  per-source destination, data (source i at slice i).
REQ-014 long_issue, long_waddr, long_lat  in  1, 5, LAT_W  multi-cycle op issued; destination; cycles until result.
REQ-015 rs, rt  out  5 each  regfile read addresses = id_inst[25:21], id_inst[20:16].
REQ-016 id_valid, id_pc, id_inst  out  1, 32, 32  decode-stage valid, PC, instruction.
REQ-017 op1, op2  out  DATA_W each  resolved rs / rt operands.
REQ-018 stallreq  out  1  ID interlock request.
REQ-019 stall_cnt  out  32  count of cycles with stallreq==1.

Function
REQ-020 Stage register priority: flush -> bubble; else stall[1]==1 and stall[2]==0 -> bubble; else stall[1]==0 -> load if_valid, if_pc; else hold.
REQ-021 Bubble SHALL set id_valid=0, id_pc=0, instruction hold cleared.
REQ-022 First cycle with stall[2]==1 and hold_vld==0 SHALL capture inst_sram_rdata into hold reg and set hold_vld.
REQ-023 hold_vld SHALL clear on any cycle with stall[2]==0 or flush.
REQ-024 id_inst SHALL be hold reg when hold_vld==1, else inst_sram_rdata; 0 when id_valid==0.
REQ-025 op1 SHALL be: 0 if rs==0; else fwd_wdata of lowest index i with fwd_we[i] and fwd_waddr[i]==rs; else rf_rdata1. op2 identical for rt/rf_rdata2.
REQ-026 Load interlock: stallreq SHALL assert when, for rs (need_rs) or rt (need_rt), nonzero, the selected (lowest matching) source has fwd_is_load==1.
REQ-027 Long-latency scoreboard: long_issue SHALL load busy_cnt=long_lat and busy_reg=long_waddr; busy_cnt decrements by 1 per cycle, saturating at 0, independent of stall.
REQ-028 long_issue while busy_cnt!=0 SHALL reload (new issue wins); long_issue with long_lat==0 or long_waddr==0 SHALL leave scoreboard idle.
REQ-029 stallreq SHALL also assert when busy_cnt!=0 and a needed nonzero rs/rt equals busy_reg.
REQ-030 stallreq SHALL be 0 when id_valid==0; purely combinational from current state and inputs (zero latency).
REQ-031 stall_cnt SHALL increment each cycle stallreq==1, saturating at 32'hFFFFFFFF.
REQ-032 flush SHALL not clear scoreboard or stall_cnt.

Reset
REQ-033 rst==0 SHALL force id_valid=0, id_pc=0, hold_vld=0, hold reg=0, busy_cnt=0, busy_reg=0, stall_cnt=0 on the same edge; reset mid-stall or mid-countdown drops all state.
REQ-034 During and after reset stallreq=0, op1/op2 follow REQ-025 from inputs.

Verification
REQ-035 Load if_pc=0xBFC00000, inst=0x24010005, fwd_we=0 -> next cycle id_pc=0xBFC00000, op1=rf_rdata1.
REQ-036 rs=3 with fwd_we=3'b011, waddr0=3 data0=0x11, waddr1=3 data1=0x22 -> op1=0x11; rs=0 same sources -> op1=0.
REQ-037 Source 0 matches rt=4 with fwd_is_load=1, need_rt=1 -> stallreq=1, stall[2]=1 three cycles while SRAM data changes -> id_inst keeps first-captured word; stall_cnt +1 per cycle.
REQ-038 long_issue, long_waddr=8, long_lat=4; next ID reads rs=8 -> stallreq=1 exactly 4 cycles after issue edge, then 0.
REQ-039 stall[1]=1, stall[2]=0 -> id_valid=0, id_pc=0; flush together with stall[2]=1 -> bubble, hold_vld=0.
REQ-040 rst=0 asserted mid-countdown (busy_cnt=3) -> next edge all state zero, stallreq=0.

Source files
------------

// File: rtl/id_operand_unit.sv
// id_operand_unit
//   Decode-stage register plus operand resolution for a 5-stage MIPS-style
//   pipeline. Holds the IF->ID register, keeps the SRAM instruction word
//   stable while ID is stalled, resolves rs/rt through an ordered bypass
//   network, and raises an interlock for load-use and long-latency hazards.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   stall[5:0]        pipeline stall vector (bit1 = IF held, bit2 = ID held)
//   flush             discard ID contents
//   if_valid, if_pc   fetch-stage valid / PC
//   inst_sram_rdata   instruction SRAM read data
//   need_rs, need_rt  decoder: instruction reads rs / rt
//   rf_rdata1/2       regfile read data for rs / rt
//   fwd_we/is_load    per bypass source write enable / result-not-ready
//   fwd_waddr/wdata   per bypass source destination and data (slice i)
//   long_issue/waddr/lat  multi-cycle op issue, destination, latency
//   rs, rt            regfile read addresses from id_inst
//   id_valid/pc/inst  decode-stage valid, PC, instruction
//   op1, op2          resolved operands
//   stallreq          ID interlock request (combinational)
//   stall_cnt         saturating count of cycles with stallreq==1
module id_operand_unit #(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int LAT_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                stall,
  input  logic                      flush,
  input  logic                      if_valid,
  input  logic [31:0]               if_pc,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      need_rs,
  input  logic                      need_rt,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*5-1:0]      fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic                      long_issue,
  input  logic [4:0]                long_waddr,
  input  logic [LAT_W-1:0]          long_lat,
  output logic [4:0]                rs,
  output logic [4:0]                rt,
  output logic                      id_valid,
  output logic [31:0]               id_pc,
  output logic [31:0]               id_inst,
  output logic [DATA_W-1:0]         op1,
  output logic [DATA_W-1:0]         op2,
  output logic                      stallreq,
  output logic [31:0]               stall_cnt
);

  typedef struct packed {
    logic              hit;
    logic              load;
    logic [DATA_W-1:0] data;
  } fwd_sel_t;

  // Lowest-index (youngest) matching source wins: scan from oldest to
  // youngest so later matches overwrite earlier ones.
  function automatic fwd_sel_t fwd_lookup(
    input logic [4:0]                addr,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD-1:0]        ld,
    input logic [NUM_FWD*5-1:0]      waddr,
    input logic [NUM_FWD*DATA_W-1:0] wdata
  );
    fwd_sel_t r;
    r = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && (waddr[i*5 +: 5] == addr)) begin
        r.hit  = 1'b1;
        r.load = ld[i];
        r.data = wdata[i*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    return (v == '0) ? v : v - LAT_W'(1);
  endfunction

  logic              id_valid_q, id_valid_d;
  logic [31:0]       id_pc_q,    id_pc_d;
  logic              hold_vld_q, hold_vld_d;
  logic [31:0]       hold_q,     hold_d;
  logic [LAT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [4:0]        busy_reg_q, busy_reg_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  fwd_sel_t sel1, sel2;
  logic     haz_rs, haz_rt;

  // Only the IF/ID hold bits of the stall vector matter here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:3], stall[0]};

  // ---- decode-stage outputs ----
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_valid_q ? (hold_vld_q ? hold_q : inst_sram_rdata) : 32'h0;
  assign rs       = id_inst[25:21];
  assign rt       = id_inst[20:16];

  assign sel1 = fwd_lookup(rs, fwd_we, fwd_is_load, fwd_waddr, fwd_wdata);
  assign sel2 = fwd_lookup(rt, fwd_we, fwd_is_load, fwd_waddr, fwd_wdata);

  assign op1 = (rs == 5'd0) ? '0 : (sel1.hit ? sel1.data : rf_rdata1);
  assign op2 = (rt == 5'd0) ? '0 : (sel2.hit ? sel2.data : rf_rdata2);

  // A needed register is blocked either by a not-yet-ready youngest producer
  // or by an outstanding long-latency op writing the same register.
  assign haz_rs = need_rs && (rs != 5'd0) &&
                  ((sel1.hit && sel1.load) ||
                   ((busy_cnt_q != '0) && (rs == busy_reg_q)));
  assign haz_rt = need_rt && (rt != 5'd0) &&
                  ((sel2.hit && sel2.load) ||
                   ((busy_cnt_q != '0) && (rt == busy_reg_q)));

  // Suppressed while reset is asserted so nothing downstream freezes.
  assign stallreq  = rst && id_valid_q && (haz_rs || haz_rt);
  assign stall_cnt = stall_cnt_q;

  // ---- next-state ----
  always_comb begin
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    hold_vld_d  = hold_vld_q;
    hold_d      = hold_q;
    busy_cnt_d  = sat_dec(busy_cnt_q);
    busy_reg_d  = busy_reg_q;
    stall_cnt_d = stallreq ? sat_inc32(stall_cnt_q) : stall_cnt_q;

    // IF held but ID free means the ID slot drains into a bubble.
    if (flush || (stall[1] && !stall[2])) begin
      id_valid_d = 1'b0;
      id_pc_d    = 32'h0;
    end else if (!stall[1]) begin
      id_valid_d = if_valid;
      id_pc_d    = if_pc;
    end

    // The SRAM output moves on while ID is held, so the first stalled
    // cycle's word is latched and replayed until the stall releases.
    if (flush || !stall[2]) begin
      hold_vld_d = 1'b0;
      hold_d     = 32'h0;
    end else if (!hold_vld_q) begin
      hold_vld_d = 1'b1;
      hold_d     = inst_sram_rdata;
    end

    // A new issue always replaces the outstanding one; a degenerate issue
    // (no latency or $0 destination) leaves nothing to wait for.
    if (long_issue) begin
      if ((long_lat != '0) && (long_waddr != 5'd0)) begin
        busy_cnt_d = long_lat;
        busy_reg_d = long_waddr;
      end else begin
        busy_cnt_d = '0;
        busy_reg_d = 5'd0;
      end
    end
  end

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0;
      hold_vld_q  <= 1'b0;
      hold_q      <= 32'h0;
      busy_cnt_q  <= '0;
      busy_reg_q  <= 5'd0;
      stall_cnt_q <= 32'h0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      hold_vld_q  <= hold_vld_d;
      hold_q      <= hold_d;
      busy_cnt_q  <= busy_cnt_d;
      busy_reg_q  <= busy_reg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// Testbench for id_operand_unit: directed cycles, expected values queued per
// cycle and compared against DUT outputs on the falling clock edge.
module tb_id_operand_unit;

  localparam int NUM_FWD = 3;
  localparam int DATA_W  = 32;
  localparam int LAT_W   = 6;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [5:0]                stall;
  logic                      flush;
  logic                      if_valid;
  logic [31:0]               if_pc;
  logic [31:0]               inst_sram_rdata;
  logic                      need_rs, need_rt;
  logic [DATA_W-1:0]         rf_rdata1, rf_rdata2;
  logic [NUM_FWD-1:0]        fwd_we, fwd_is_load;
  logic [NUM_FWD*5-1:0]      fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic                      long_issue;
  logic [4:0]                long_waddr;
  logic [LAT_W-1:0]          long_lat;
  logic [4:0]                rs, rt;
  logic                      id_valid;
  logic [31:0]               id_pc, id_inst;
  logic [DATA_W-1:0]         op1, op2;
  logic                      stallreq;
  logic [31:0]               stall_cnt;

  id_operand_unit #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .need_rs(need_rs), .need_rt(need_rt),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .long_issue(long_issue), .long_waddr(long_waddr), .long_lat(long_lat),
    .rs(rs), .rt(rt), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .op1(op1), .op2(op2), .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int { K_VALID, K_PC, K_INST, K_OP1, K_OP2, K_SR, K_SC, K_RS, K_RT } kind_t;
  typedef struct { kind_t kind; logic [31:0] val; } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_sc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input kind_t k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // stallreq plus the stall_cnt value visible in the same cycle; the model
  // counter advances after each cycle expected to stall.
  task automatic exp_sr(input logic v);
    push(K_SR, {31'h0, v});
    push(K_SC, exp_sc);
    if (v) exp_sc = exp_sc + 32'd1;
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_VALID: chk("id_valid",  {31'h0, id_valid}, e.val);
        K_PC:    chk("id_pc",     id_pc,             e.val);
        K_INST:  chk("id_inst",   id_inst,           e.val);
        K_OP1:   chk("op1",       op1,               e.val);
        K_OP2:   chk("op2",       op2,               e.val);
        K_SR:    chk("stallreq",  {31'h0, stallreq}, e.val);
        K_SC:    chk("stall_cnt", stall_cnt,         e.val);
        K_RS:    chk("rs",        {27'h0, rs},       e.val);
        default: chk("rt",        {27'h0, rt},       e.val);
      endcase
    end
  endtask

  // Inputs are set before calling; outputs checked on the falling edge,
  // then the rising edge commits the cycle.
  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t, input logic [15:0] lo);
    return {6'h0, s, t, lo};
  endfunction

  task automatic set_fwd(input int i, input logic [4:0] a, input logic [31:0] d);
    fwd_waddr[i*5 +: 5]         = a;
    fwd_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; if_valid = 1'b0; if_pc = '0;
    inst_sram_rdata = '0; need_rs = 1'b0; need_rt = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; fwd_we = '0; fwd_is_load = '0;
    fwd_waddr = '0; fwd_wdata = '0; long_issue = 1'b0; long_waddr = '0; long_lat = '0;
    @(posedge clk);
    #1;

    // Reset held: state zero, stallreq low, op1 from rs==0
    rf_rdata1 = 32'hAAAA; fwd_we = 3'b001; fwd_is_load = 3'b001; need_rs = 1'b1;
    push(K_VALID, 0); push(K_PC, 0); push(K_INST, 0); push(K_OP1, 0);
    exp_sr(0);
    cyc();
    rst = 1'b1; fwd_we = '0; fwd_is_load = '0; need_rs = 1'b0;

    // Basic load into ID
    if_valid = 1'b1; if_pc = 32'hBFC0_0000; inst_sram_rdata = 32'h2401_0005;
    exp_sr(0);
    cyc();
    if_valid = 1'b0; rf_rdata1 = 32'h0; rf_rdata2 = 32'h55;
    push(K_VALID, 1); push(K_PC, 32'hBFC0_0000); push(K_INST, 32'h2401_0005);
    push(K_RS, 0); push(K_RT, 1); push(K_OP1, 0); push(K_OP2, 32'h55);
    cyc();

    // Bypass priority
    if_valid = 1'b1; if_pc = 32'h100;
    push(K_VALID, 0); push(K_INST, 0);
    cyc();
    if_pc = 32'h104; inst_sram_rdata = mk(3, 4, 0); need_rs = 1'b1; need_rt = 1'b1;
    rf_rdata1 = 32'h99; rf_rdata2 = 32'h44;
    fwd_we = 3'b011; set_fwd(0, 3, 32'h11); set_fwd(1, 3, 32'h22);
    push(K_VALID, 1); push(K_PC, 32'h100); push(K_RS, 3); push(K_OP1, 32'h11); push(K_OP2, 32'h44);
    exp_sr(0);
    cyc();
    fwd_we = 3'b010;
    push(K_PC, 32'h104); push(K_OP1, 32'h22);
    cyc();
    inst_sram_rdata = mk(0, 4, 0); fwd_we = 3'b111; set_fwd(2, 4, 32'h33);
    push(K_OP1, 0); push(K_OP2, 32'h33);
    exp_sr(0);
    cyc();

    // Load-use interlock with ID held; SRAM word changes underneath
    need_rs = 1'b0; need_rt = 1'b1;
    fwd_we = 3'b001; fwd_is_load = 3'b001; set_fwd(0, 4, 32'h77);
    stall = 6'b000110; inst_sram_rdata = 32'h0004_0001;
    push(K_INST, 32'h0004_0001); exp_sr(1);
    cyc();
    inst_sram_rdata = 32'h00A5_0002;
    push(K_VALID, 1); push(K_INST, 32'h0004_0001); exp_sr(1);
    cyc();
    inst_sram_rdata = 32'h0123_0003;
    push(K_INST, 32'h0004_0001); exp_sr(1);
    cyc();
    stall = '0; fwd_we = '0; fwd_is_load = '0;
    push(K_INST, 32'h0004_0001); exp_sr(0);
    cyc();
    inst_sram_rdata = mk(0, 6, 0);
    push(K_INST, mk(0, 6, 0)); exp_sr(0);
    cyc();

    // Long-latency scoreboard: stall exactly 4 cycles after issue
    need_rs = 1'b1; need_rt = 1'b0; inst_sram_rdata = mk(8, 0, 0);
    long_issue = 1'b1; long_waddr = 5'd8; long_lat = 6'd4;
    exp_sr(0);
    cyc();
    long_issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_sr(1);
      cyc();
    end
    exp_sr(0);
    cyc();

    // Reissue with zero latency idles the scoreboard
    long_issue = 1'b1; long_lat = 6'd4;
    exp_sr(0);
    cyc();
    long_lat = 6'd0;
    exp_sr(1);
    cyc();
    long_issue = 1'b0;
    exp_sr(0);
    cyc();

    // IF held / ID free -> bubble
    stall = 6'b000010;
    exp_sr(0);
    cyc();
    stall = '0; if_pc = 32'h200;
    fwd_we = 3'b001; fwd_is_load = 3'b001; set_fwd(0, 8, 32'h1);
    push(K_VALID, 0); push(K_PC, 0); push(K_INST, 0); exp_sr(0);
    cyc();
    // flush wins over ID hold; hold register must not be left set
    fwd_we = '0; fwd_is_load = '0;
    flush = 1'b1; stall = 6'b000110; inst_sram_rdata = 32'hDEAD_0000;
    push(K_VALID, 1); push(K_PC, 32'h200); push(K_INST, 32'hDEAD_0000);
    cyc();
    flush = 1'b0; stall = '0; if_pc = 32'h204;
    push(K_VALID, 0); push(K_PC, 0); push(K_INST, 0);
    cyc();
    inst_sram_rdata = 32'h00C0_0000;
    push(K_VALID, 1); push(K_PC, 32'h204); push(K_INST, 32'h00C0_0000);
    cyc();

    // Reset mid-countdown
    inst_sram_rdata = mk(8, 0, 0);
    long_issue = 1'b1; long_waddr = 5'd8; long_lat = 6'd4;
    exp_sr(0);
    cyc();
    long_issue = 1'b0;
    exp_sr(1);
    cyc();
    rst = 1'b0;
    exp_sr(0);
    cyc();
    rst = 1'b1; exp_sc = 32'h0;
    push(K_VALID, 0); push(K_PC, 0); exp_sr(0);
    cyc();
    push(K_VALID, 1); exp_sr(0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
